// File: rtl/csr_latch_pkg.sv
// ============================================================================
// Module      : csr_latch_pkg
// Description : Shared types and constants for the gated SR latch checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_latch_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_KNOWN   = 2'd2,
        ST_FORBID  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DEC_HOLD = 2'd0,
        DEC_SET  = 2'd1,
        DEC_RST  = 2'd2,
        DEC_FBD  = 2'd3
    } dec_t;

    // Synchronizer idle values: enable off, set/reset released, Q low.
    localparam logic c_rst_c    = 1'b0;
    localparam logic c_rst_s_n  = 1'b1;
    localparam logic c_rst_r_n  = 1'b1;
    localparam logic c_rst_q    = 1'b0;
    localparam logic c_rst_qbar = 1'b1;

    function automatic dec_t decode(input logic c, input logic s_n, input logic r_n);
        dec_t d;
        d = DEC_HOLD;
        if (c) begin
            case ({s_n, r_n})
                2'b01:   d = DEC_SET;
                2'b10:   d = DEC_RST;
                2'b00:   d = DEC_FBD;
                default: d = DEC_HOLD;
            endcase
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
// ============================================================================
// Module      : sync_bit
// Description : Multi-stage single-bit synchronizer with selectable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/csr_latch_checker.sv
// ============================================================================
// Module      : csr_latch_checker
// Description : Passive checker for a gated SR latch with event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_latch_checker
    import csr_latch_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lat_c,
    input  logic             lat_s_n,
    input  logic             lat_r_n,
    input  logic             lat_q,
    input  logic             lat_qbar,
    output logic             model_q,
    output logic             model_valid,
    output logic             forbid,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] forbid_cnt,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] rst_cnt
);

    localparam int                 c_set_w       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max     = '1;
    localparam logic [4:0]         c_sync_rst    = {c_rst_c, c_rst_s_n, c_rst_r_n, c_rst_q, c_rst_qbar};

    logic [4:0] w_raw;
    logic [4:0] w_syn;
    logic       w_c_s, w_s_s, w_r_s, w_q_s, w_qb_s;

    assign w_raw = {lat_c, lat_s_n, lat_r_n, lat_q, lat_qbar};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sync
            sync_bit #(
                .STAGES  (SYNC_STAGES),
                .RST_VAL (c_sync_rst[gi])
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (w_raw[gi]),
                .q     (w_syn[gi])
            );
        end
    endgenerate

    assign {w_c_s, w_s_s, w_r_s, w_q_s, w_qb_s} = w_syn;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_prev;
    logic [c_set_w-1:0] r_settle, w_settle_nxt;
    logic               r_model_q, w_model_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_err_cnt, r_fbd_cnt, r_set_cnt, r_rst_cnt;
    dec_t               w_dec;
    logic               w_change, w_is_set, w_is_rst, w_accept, w_err;
    logic               w_inc_set, w_inc_rst, w_inc_fbd;

    assign w_dec    = decode(w_c_s, w_s_s, w_r_s);
    assign w_change = ({w_c_s, w_s_s, w_r_s} != r_prev);
    assign w_is_set = (w_dec == DEC_SET);
    assign w_is_rst = (w_dec == DEC_RST);
    assign w_accept = w_is_set | w_is_rst;
    assign w_err    = (r_state == ST_KNOWN) && ((w_q_s != r_model_q) || (w_qb_s == w_q_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNKNOWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_model_nxt  = r_model_q;
        w_valid_nxt  = r_valid;
        w_inc_set    = 1'b0;
        w_inc_rst    = 1'b0;
        w_inc_fbd    = 1'b0;

        if (w_dec == DEC_FBD) begin
            w_state_nxt = ST_FORBID;
            if (r_state != ST_FORBID) begin
                w_inc_fbd   = 1'b1;
                w_valid_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ST_UNKNOWN, ST_FORBID: begin
                    // Leaving FORBID without a clean set/reset leaves the latch indeterminate.
                    if (w_accept) begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = '0;
                        w_model_nxt  = w_is_set;
                        w_inc_set    = w_is_set;
                        w_inc_rst    = w_is_rst;
                    end else if (r_state == ST_FORBID) begin
                        w_state_nxt = ST_UNKNOWN;
                    end
                end
                ST_SETTLE: begin
                    if (w_change) begin
                        w_settle_nxt = '0;
                        if (w_accept) begin
                            w_model_nxt = w_is_set;
                            w_inc_set   = w_is_set;
                            w_inc_rst   = w_is_rst;
                        end
                    end else if (r_settle == c_settle_last) begin
                        w_state_nxt = ST_KNOWN;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_settle_nxt = r_settle + 1'b1;
                    end
                end
                ST_KNOWN: begin
                    if (w_change) begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = '0;
                        if (w_accept) begin
                            w_model_nxt = w_is_set;
                            w_inc_set   = w_is_set;
                            w_inc_rst   = w_is_rst;
                        end
                    end
                end
                default: w_state_nxt = ST_UNKNOWN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= {c_rst_c, c_rst_s_n, c_rst_r_n};
            r_settle  <= '0;
            r_model_q <= 1'b0;
            r_valid   <= 1'b0;
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
            r_fbd_cnt <= '0;
            r_set_cnt <= '0;
            r_rst_cnt <= '0;
        end else begin
            r_prev    <= {w_c_s, w_s_s, w_r_s};
            r_settle  <= w_settle_nxt;
            r_model_q <= w_model_nxt;
            r_valid   <= w_valid_nxt;
            if (w_err) begin
                r_sticky <= 1'b1;
            end
            if (w_err && (r_err_cnt != c_cnt_max)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_inc_fbd && (r_fbd_cnt != c_cnt_max)) begin
                r_fbd_cnt <= r_fbd_cnt + 1'b1;
            end
            if (w_inc_set && (r_set_cnt != c_cnt_max)) begin
                r_set_cnt <= r_set_cnt + 1'b1;
            end
            if (w_inc_rst && (r_rst_cnt != c_cnt_max)) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    assign model_q     = r_model_q;
    assign model_valid = r_valid;
    assign forbid      = (r_state == ST_FORBID);
    assign err         = w_err;
    assign err_sticky  = r_sticky;
    assign err_cnt     = r_err_cnt;
    assign forbid_cnt  = r_fbd_cnt;
    assign set_cnt     = r_set_cnt;
    assign rst_cnt     = r_rst_cnt;

endmodule

`default_nettype wire
